tree_node_mem_arbiter: RTL and testbench
========================================

Name: tree_node_mem_arbiter

Overview:
- Shares one single-port node RAM between the two lookup lanes of a tree level and a configuration writer.
- Grants at most one RAM access per cycle: round-robin between the lanes, aged priority for configuration writes.
- Aligns the 1-cycle RAM read data with the delayed packet and match flag.
- Presents per-lane registered outputs (packet, valid, node, matched) to the next tree level.

Parameters:
- PACKET_WIDTH, 104, packet header width.
- NODE_WIDTH, 40, tree node word width.
- ADDR_WIDTH, 10, node RAM address width.
- CFG_MAX_WAIT, 8, cycles a pending config write may be refused before it is forced.

Ports:
- clk  in  1  clock
- RSTn  in  1  asynchronous active-low reset
- req1 / req2  in  1  lane lookup request
- packet_in1 / packet_in2  in  PACKET_WIDTH  lane packet header
- addr_in1 / addr_in2  in  ADDR_WIDTH  node address to read
- matched_in1 / matched_in2  in  1  match flag from previous level
- gnt1 / gnt2  out  1  combinational grant, same cycle as request
- cfg_wr_req  in  1  config write request
- cfg_addr  in  ADDR_WIDTH  config write address
- cfg_data  in  NODE_WIDTH  config write data
- cfg_wr_ack  out  1  combinational grant for config write
- mem_en  out  1  RAM enable
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_WIDTH  RAM address
- mem_wdata  out  NODE_WIDTH  RAM write data
- mem_rdata  in  NODE_WIDTH  RAM read data, valid 1 cycle after a read
- packet_out1 / packet_out2  out  PACKET_WIDTH  registered packet
- data_valid_out1 / data_valid_out2  out  1  one-cycle valid pulse
- node_out1 / node_out2  out  NODE_WIDTH  node word read for the lane
- matched_out1 / matched_out2  out  1  registered match flag
- conflict_cnt  out  32  lane-conflict cycle count (see Optional Feature)

Behaviour:
- Reset: the following clear asynchronously to 0:
  - all registered outputs and conflict_cnt;
  - rr_ptr (0 = lane1 was served last, so lane2 is preferred next);
  - cfg_wait, and state = NORMAL.
- Combinational outputs are 0 whenever no request is pending.
- Handshake: a requester holds req and its data stable until it sees grant high; the transfer happens in that cycle.
- At most one of gnt1, gnt2, cfg_wr_ack is high per cycle. mem_en equals the OR of the three grants.
- State NORMAL:
  - Lane requests take priority over config.
  - One lane requesting: that lane is granted.
  - Both lanes requesting: the lane not served last is granted.
  - Config is acked only when neither lane requests.
  - cfg_wait increments each cycle cfg_wr_req is high and not acked; it saturates at CFG_MAX_WAIT.
  - Moves to CFG_FORCE when cfg_wait reaches CFG_MAX_WAIT.
- State CFG_FORCE:
  - cfg_wr_ack = 1, mem_we = 1, lanes are not granted.
  - Next cycle returns to NORMAL with cfg_wait cleared.
  - If cfg_wr_req drops before the force (protocol violation), return to NORMAL and clear cfg_wait.
- rr_ptr updates only on a lane grant.
- Read latency: a lane granted in cycle N produces outputs in cycle N+1:
  - node_outX = mem_rdata;
  - packet_outX and matched_outX = values captured at grant;
  - data_valid_outX = 1 for exactly one cycle.
- Ungranted lane: data_valid_outX = 0; packet, node and matched outputs hold their previous values.
- Write followed by read of the same address the next cycle returns the new data; the RAM is write-first and needs no bypass.
- Mid-operation reset clears the in-flight read: no valid pulse after reset is released.

Optional Feature:
- ARB_STATS_EN defined: conflict_cnt increments (wrapping at 2^32) every cycle in which req1 and req2 are both high.
- Undefined: conflict_cnt is tied to 0 and the counter logic is absent.

Decomposition:
- Package tree_pkg:
  - PACKET_WIDTH, NODE_WIDTH, ADDR_WIDTH constants;
  - arb_state_t enum {NORMAL, CFG_FORCE};
  - grant encoding enum {GNT_NONE, GNT_L1, GNT_L2, GNT_CFG}.
- Sub-module rr_arbiter2: 2-way round-robin with rr_ptr, inputs req1/req2, outputs one-hot grant.

Test Plan:
- Only req1, addr 5, RAM[5]=0xAA: gnt1=1 in cycle N; cycle N+1 node_out1=0xAA, data_valid_out1=1, data_valid_out2=0.
- req1 and req2 high for 4 cycles after reset: grants alternate L2, L1, L2, L1; with ARB_STATS_EN, conflict_cnt=4.
- Both lanes saturating, cfg_wr_req held with CFG_MAX_WAIT=8: cfg_wr_ack after exactly 8 refused cycles; no lane grant that cycle; lanes resume the next cycle.
- cfg write addr 3 data 0x55, then req2 addr 3 the next cycle: node_out2=0x55.
- Lanes idle, cfg_wr_req high: immediate ack, mem_we=1, cfg_wait stays 0.
- RSTn asserted the cycle after a lane grant: all outputs 0; no data_valid pulse after release.

Source files
------------

// File: rtl/tree_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tree_pkg
// Description : Shared constants and encodings for the tree-level node RAM
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package tree_pkg;

    localparam int PACKET_WIDTH = 104;
    localparam int NODE_WIDTH   = 40;
    localparam int ADDR_WIDTH   = 10;

    // NORMAL: lanes win over config; CFG_FORCE: one cycle reserved for config
    typedef enum logic {
        NORMAL    = 1'b0,
        CFG_FORCE = 1'b1
    } arb_state_t;

    // Which requester owns the RAM port this cycle
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_L1   = 2'd1,
        GNT_L2   = 2'd2,
        GNT_CFG  = 2'd3
    } grant_t;

endpackage : tree_pkg
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-way round-robin arbiter. rr_ptr records the lane served
//               last (0 = lane1, 1 = lane2); on a conflict the other lane wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2 (
    input  logic       clk,
    input  logic       RSTn,
    input  logic       req1,
    input  logic       req2,
    output logic [1:0] grant
);

    logic rr_ptr_q;
    logic rr_ptr_d;

    // One-hot grant; on conflict the lane not served last is picked
    always_comb begin
        grant    = 2'b00;
        rr_ptr_d = rr_ptr_q;
        if (req1 && req2) begin
            grant = rr_ptr_q ? 2'b01 : 2'b10;
        end else begin
            grant = {req2, req1};
        end
        if (grant[0]) begin
            rr_ptr_d = 1'b0;
        end else if (grant[1]) begin
            rr_ptr_d = 1'b1;
        end
    end

    // Pointer moves only when a lane is actually granted
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            rr_ptr_q <= 1'b0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/tree_node_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tree_node_mem_arbiter
// Description : Shares one single-port node RAM between two lookup lanes and a
//               configuration writer. Lanes are round-robin, config writes are
//               aged and forced after CFG_MAX_WAIT refused cycles. Read data is
//               aligned with the packet/match flag captured at grant.
//               Optional macro ARB_STATS_EN enables the lane-conflict counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tree_node_mem_arbiter #(
    parameter int PACKET_WIDTH = tree_pkg::PACKET_WIDTH,
    parameter int NODE_WIDTH   = tree_pkg::NODE_WIDTH,
    parameter int ADDR_WIDTH   = tree_pkg::ADDR_WIDTH,
    parameter int CFG_MAX_WAIT = 8
) (
    input  logic                    clk,
    input  logic                    RSTn,
    input  logic                    req1,
    input  logic                    req2,
    input  logic [PACKET_WIDTH-1:0] packet_in1,
    input  logic [PACKET_WIDTH-1:0] packet_in2,
    input  logic [ADDR_WIDTH-1:0]   addr_in1,
    input  logic [ADDR_WIDTH-1:0]   addr_in2,
    input  logic                    matched_in1,
    input  logic                    matched_in2,
    output logic                    gnt1,
    output logic                    gnt2,
    input  logic                    cfg_wr_req,
    input  logic [ADDR_WIDTH-1:0]   cfg_addr,
    input  logic [NODE_WIDTH-1:0]   cfg_data,
    output logic                    cfg_wr_ack,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [NODE_WIDTH-1:0]   mem_wdata,
    input  logic [NODE_WIDTH-1:0]   mem_rdata,
    output logic [PACKET_WIDTH-1:0] packet_out1,
    output logic [PACKET_WIDTH-1:0] packet_out2,
    output logic                    data_valid_out1,
    output logic                    data_valid_out2,
    output logic [NODE_WIDTH-1:0]   node_out1,
    output logic [NODE_WIDTH-1:0]   node_out2,
    output logic                    matched_out1,
    output logic                    matched_out2,
    output logic [31:0]             conflict_cnt
);

    import tree_pkg::*;

    localparam int             WAIT_W   = (CFG_MAX_WAIT < 1) ? 1 : $clog2(CFG_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(CFG_MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [WAIT_W-1:0] cfg_wait_q, cfg_wait_d;
    logic [1:0]        lane_grant;
    logic              lane_req1, lane_req2;
    grant_t            sel;

    logic                    valid1_q, valid2_q;
    logic [PACKET_WIDTH-1:0] packet1_q, packet2_q;
    logic                    matched1_q, matched2_q;
    logic [NODE_WIDTH-1:0]   node1_q, node2_q;

    // Lanes are locked out while a config write is being forced
    assign lane_req1 = req1 && (state_q != CFG_FORCE);
    assign lane_req2 = req2 && (state_q != CFG_FORCE);

    rr_arbiter2 u_rr (
        .clk   (clk),
        .RSTn  (RSTn),
        .req1  (lane_req1),
        .req2  (lane_req2),
        .grant (lane_grant)
    );

    // Resolve the single RAM owner for this cycle
    always_comb begin
        sel = GNT_NONE;
        if (lane_grant[0]) begin
            sel = GNT_L1;
        end else if (lane_grant[1]) begin
            sel = GNT_L2;
        end else if (cfg_wr_req && ((state_q == CFG_FORCE) || (!req1 && !req2))) begin
            sel = GNT_CFG;
        end
    end

    assign gnt1       = (sel == GNT_L1);
    assign gnt2       = (sel == GNT_L2);
    assign cfg_wr_ack = (sel == GNT_CFG);
    assign mem_en     = gnt1 || gnt2 || cfg_wr_ack;
    assign mem_we     = cfg_wr_ack;
    assign mem_wdata  = cfg_wr_ack ? cfg_data : '0;

    // RAM address follows the granted requester, idle address is zero
    always_comb begin
        mem_addr = '0;
        case (sel)
            GNT_L1:  mem_addr = addr_in1;
            GNT_L2:  mem_addr = addr_in2;
            GNT_CFG: mem_addr = cfg_addr;
            default: mem_addr = '0;
        endcase
    end

    // Config aging: count refused cycles, force the write once the limit is hit
    always_comb begin
        state_d    = state_q;
        cfg_wait_d = cfg_wait_q;
        case (state_q)
            NORMAL: begin
                if (!cfg_wr_req || (sel == GNT_CFG)) begin
                    cfg_wait_d = '0;
                end else if (cfg_wait_q < WAIT_MAX) begin
                    cfg_wait_d = cfg_wait_q + WAIT_W'(1);
                end
                if (cfg_wait_d == WAIT_MAX) begin
                    state_d = CFG_FORCE;
                end
            end
            CFG_FORCE: begin
                state_d    = NORMAL;
                cfg_wait_d = '0;
            end
            default: begin
                state_d    = NORMAL;
                cfg_wait_d = '0;
            end
        endcase
    end

    // Arbitration state register
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state_q    <= NORMAL;
            cfg_wait_q <= '0;
        end else begin
            state_q    <= state_d;
            cfg_wait_q <= cfg_wait_d;
        end
    end

    // Per-lane output stage: capture at grant, latch node word while it is shown
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            valid1_q   <= 1'b0;
            valid2_q   <= 1'b0;
            packet1_q  <= '0;
            packet2_q  <= '0;
            matched1_q <= 1'b0;
            matched2_q <= 1'b0;
            node1_q    <= '0;
            node2_q    <= '0;
        end else begin
            valid1_q <= gnt1;
            valid2_q <= gnt2;
            if (gnt1) begin
                packet1_q  <= packet_in1;
                matched1_q <= matched_in1;
            end
            if (gnt2) begin
                packet2_q  <= packet_in2;
                matched2_q <= matched_in2;
            end
            if (valid1_q) begin
                node1_q <= mem_rdata;
            end
            if (valid2_q) begin
                node2_q <= mem_rdata;
            end
        end
    end

    assign data_valid_out1 = valid1_q;
    assign data_valid_out2 = valid2_q;
    assign packet_out1     = packet1_q;
    assign packet_out2     = packet2_q;
    assign matched_out1    = matched1_q;
    assign matched_out2    = matched2_q;
    // RAM data arrives the cycle after grant; show it live then hold it
    assign node_out1       = valid1_q ? mem_rdata : node1_q;
    assign node_out2       = valid2_q ? mem_rdata : node2_q;

`ifdef ARB_STATS_EN
    logic [31:0] conflict_q;

    // Count every cycle in which both lanes contend
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            conflict_q <= '0;
        end else if (req1 && req2) begin
            conflict_q <= conflict_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule : tree_node_mem_arbiter
`default_nettype wire

// File: tb/tb_tree_node_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_tree_node_mem_arbiter
// Description : Self-checking bench for tree_node_mem_arbiter: directed
//               scenarios plus randomized lane/config traffic compared against
//               a behavioural model of the arbitration rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tree_node_mem_arbiter;

    localparam int PW   = 104;
    localparam int NW   = 40;
    localparam int AW   = 10;
    localparam int MAXW = 8;

    logic          clk = 1'b0;
    logic          RSTn = 1'b0;
    logic          req1 = 0, req2 = 0, matched_in1 = 0, matched_in2 = 0;
    logic [PW-1:0] packet_in1 = '0, packet_in2 = '0;
    logic [AW-1:0] addr_in1 = '0, addr_in2 = '0, cfg_addr = '0;
    logic          cfg_wr_req = 0;
    logic [NW-1:0] cfg_data = '0;
    logic [NW-1:0] mem_rdata = '0;
    logic          gnt1, gnt2, cfg_wr_ack, mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [NW-1:0] mem_wdata, node_out1, node_out2;
    logic [PW-1:0] packet_out1, packet_out2;
    logic          data_valid_out1, data_valid_out2, matched_out1, matched_out2;
    logic [31:0]   conflict_cnt;

    tree_node_mem_arbiter dut (
        .clk(clk), .RSTn(RSTn),
        .req1(req1), .req2(req2),
        .packet_in1(packet_in1), .packet_in2(packet_in2),
        .addr_in1(addr_in1), .addr_in2(addr_in2),
        .matched_in1(matched_in1), .matched_in2(matched_in2),
        .gnt1(gnt1), .gnt2(gnt2),
        .cfg_wr_req(cfg_wr_req), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_wr_ack(cfg_wr_ack),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .packet_out1(packet_out1), .packet_out2(packet_out2),
        .data_valid_out1(data_valid_out1), .data_valid_out2(data_valid_out2),
        .node_out1(node_out1), .node_out2(node_out2),
        .matched_out1(matched_out1), .matched_out2(matched_out2),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    // Write-first single-port RAM with one cycle read latency
    logic [NW-1:0] ram     [0:(1<<AW)-1];
    logic [NW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_wdata;
                mem_rdata     <= mem_wdata;
            end else begin
                mem_rdata <= ram[mem_addr];
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%0h expected=%0h", tag, act, exp);
        end
    endtask

    // Stimulus intent for the coming cycle
    logic          t_r1 = 0, t_r2 = 0, t_m1 = 0, t_m2 = 0, t_cr = 0;
    logic [PW-1:0] t_p1 = '0, t_p2 = '0;
    logic [AW-1:0] t_a1 = '0, t_a2 = '0, t_ca = '0;
    logic [NW-1:0] t_cd = '0;

    // Reference model: who was served last, how long config has waited
    int            m_last    = 1;
    int            m_refused = 0;
    bit            m_forced  = 0;
    logic          e_v1 = 0, e_v2 = 0, e_m1 = 0, e_m2 = 0;
    logic [PW-1:0] e_p1 = '0, e_p2 = '0;
    logic [NW-1:0] e_n1 = '0, e_n2 = '0;
    logic [31:0]   e_cnt = '0;
    bit            obs_g1, obs_g2, obs_ack, obs_we;
    int            last_g;

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    task automatic model_reset();
        m_last = 1; m_refused = 0; m_forced = 0;
        e_v1 = 0; e_v2 = 0; e_m1 = 0; e_m2 = 0;
        e_p1 = '0; e_p2 = '0; e_n1 = '0; e_n2 = '0; e_cnt = '0;
    endtask

    // Apply one cycle of stimulus, compare every output, advance the model
    task automatic step();
        int g;
        logic [AW-1:0] ea;
        @(negedge clk);
        req1 = t_r1; req2 = t_r2; addr_in1 = t_a1; addr_in2 = t_a2;
        packet_in1 = t_p1; packet_in2 = t_p2; matched_in1 = t_m1; matched_in2 = t_m2;
        cfg_wr_req = t_cr; cfg_addr = t_ca; cfg_data = t_cd;
        #1;
        if (m_forced)            g = t_cr ? 3 : 0;
        else if (t_r1 && t_r2)   g = (m_last == 1) ? 2 : 1;
        else if (t_r1)           g = 1;
        else if (t_r2)           g = 2;
        else if (t_cr)           g = 3;
        else                     g = 0;
        ea = (g == 1) ? t_a1 : (g == 2) ? t_a2 : (g == 3) ? t_ca : '0;
        check_val("gnt1", gnt1, g == 1);
        check_val("gnt2", gnt2, g == 2);
        check_val("cfg_ack", cfg_wr_ack, g == 3);
        check_val("mem_en", mem_en, g != 0);
        check_val("mem_we", mem_we, g == 3);
        check_val("mem_addr", mem_addr, ea);
        check_val("mem_wdata", mem_wdata, (g == 3) ? t_cd : '0);
        check_val("valid1", data_valid_out1, e_v1);
        check_val("valid2", data_valid_out2, e_v2);
        check_val("pkt1", packet_out1, e_p1);
        check_val("pkt2", packet_out2, e_p2);
        check_val("match1", matched_out1, e_m1);
        check_val("match2", matched_out2, e_m2);
        check_val("node1", node_out1, e_n1);
        check_val("node2", node_out2, e_n2);
        check_val("conflict_cnt", conflict_cnt, e_cnt);
        obs_g1 = gnt1; obs_g2 = gnt2; obs_ack = cfg_wr_ack; obs_we = mem_we;
`ifdef ARB_STATS_EN
        if (t_r1 && t_r2) e_cnt = e_cnt + 32'd1;
`endif
        e_v1 = (g == 1);
        e_v2 = (g == 2);
        if (g == 1) begin e_p1 = t_p1; e_m1 = t_m1; e_n1 = ref_mem[t_a1]; m_last = 1; end
        if (g == 2) begin e_p2 = t_p2; e_m2 = t_m2; e_n2 = ref_mem[t_a2]; m_last = 2; end
        if (g == 3) ref_mem[t_ca] = t_cd;
        if (m_forced) begin
            m_forced = 0; m_refused = 0;
        end else if (t_cr && g != 3) begin
            if (m_refused < MAXW) m_refused++;
            m_forced = (m_refused == MAXW);
        end else begin
            m_refused = 0;
        end
        last_g = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        t_r1 = 0; t_r2 = 0; t_cr = 0;
        req1 = 0; req2 = 0; cfg_wr_req = 0;
        RSTn = 1'b0;
        #1;
        check_val("rst_valid", {data_valid_out1, data_valid_out2}, 0);
        check_val("rst_pkt", {packet_out1, packet_out2}, 0);
        check_val("rst_node", {node_out1, node_out2}, 0);
        check_val("rst_match", {matched_out1, matched_out2}, 0);
        check_val("rst_cnt", conflict_cnt, 0);
        check_val("rst_grants", {gnt1, gnt2, cfg_wr_ack, mem_en, mem_we}, 0);
        model_reset();
        repeat (2) @(negedge clk);
        RSTn = 1'b1;
    endtask

    initial begin
        bit act1, act2, actc, got;
        int refused;
        for (int i = 0; i < (1 << AW); i++) begin
            ram[i]     = {$urandom, $urandom};
            ref_mem[i] = ram[i];
        end
        ram[5] = 40'hAA; ref_mem[5] = 40'hAA;

        do_reset();

        // Single lane read of a known word
        t_r1 = 1; t_a1 = 10'd5; t_p1 = rand_pkt(); t_m1 = 1;
        step();
        check_val("t1_gnt1", obs_g1, 1);
        t_r1 = 0;
        step();
        check_val("t1_node1", node_out1, 40'hAA);
        check_val("t1_valid", {data_valid_out1, data_valid_out2}, 2'b10);

        // Conflict after reset: lane2 first, then alternating
        do_reset();
        t_r1 = 1; t_r2 = 1; t_a1 = 10'd20; t_a2 = 10'd21;
        for (int i = 0; i < 4; i++) begin
            t_p1 = rand_pkt(); t_p2 = rand_pkt();
            step();
            check_val("t2_rr_order", {obs_g1, obs_g2}, (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        t_r1 = 0; t_r2 = 0;
        step();
`ifdef ARB_STATS_EN
        check_val("t2_conflicts", conflict_cnt, 32'd4);
`endif

        // Saturated lanes: config forced after exactly MAXW refusals
        t_r1 = 1; t_r2 = 1; t_cr = 1; t_ca = 10'd7; t_cd = {$urandom, $urandom};
        refused = 0; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step();
            if (obs_ack) begin
                got = 1;
                check_val("t3_refused", refused, MAXW);
                check_val("t3_lanes_blocked", {obs_g1, obs_g2}, 0);
            end else begin
                refused++;
            end
        end
        check_val("t3_acked", got, 1);
        t_cr = 0;
        step();
        check_val("t3_resume", obs_g1 | obs_g2, 1);

        // Idle lanes: immediate config write, then read-back next cycle
        t_r1 = 0; t_r2 = 0; t_cr = 1; t_ca = 10'd3; t_cd = 40'h55;
        step();
        check_val("t4_ack_we", {obs_ack, obs_we}, 2'b11);
        t_cr = 0; t_r2 = 1; t_a2 = 10'd3;
        step();
        t_r2 = 0;
        step();
        check_val("t4_node2", node_out2, 40'h55);

        // Reset landing on the cycle after a grant kills the pending pulse
        t_r1 = 1; t_a1 = 10'd9;
        step();
        t_r1 = 0;
        do_reset();
        step();
        check_val("t5_no_pulse", {data_valid_out1, data_valid_out2}, 0);

        // Randomized traffic with handshake-respecting requesters
        act1 = 0; act2 = 0; actc = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!act1 && ($urandom_range(0, 9) < 6)) begin
                act1 = 1; t_a1 = AW'($urandom_range(0, 15)); t_p1 = rand_pkt(); t_m1 = 1'($urandom);
            end
            if (!act2 && ($urandom_range(0, 9) < 6)) begin
                act2 = 1; t_a2 = AW'($urandom_range(0, 15)); t_p2 = rand_pkt(); t_m2 = 1'($urandom);
            end
            if (!actc && ($urandom_range(0, 9) < 2)) begin
                actc = 1; t_ca = AW'($urandom_range(0, 15)); t_cd = {$urandom, $urandom};
            end
            t_r1 = act1; t_r2 = act2; t_cr = actc;
            step();
            if (last_g == 1) act1 = 0;
            if (last_g == 2) act2 = 0;
            if (last_g == 3) actc = 0;
        end
        t_r1 = 0; t_r2 = 0; t_cr = 0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_tree_node_mem_arbiter
`default_nettype wire
